// File: rtl/xfire_acc_dump_pkg.sv
// Shared definitions for the xfire integrate-and-dump accumulator:
// width helpers and the per-dump disposition of a finished block.
package xfire_acc_dump_pkg;

    // What happens to a block result on the cycle its last sample is accepted
    typedef enum logic [1:0] {
        DUMP_NONE = 2'd0,
        DUMP_LOAD = 2'd1,
        DUMP_DROP = 2'd2
    } dump_action_t;

    // Ceiling log2, used to size the sample counter from the maximum block length
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Accumulator width: a full block of MAX_LEN extreme samples cannot overflow it
    function automatic int acc_width(input int din_w, input int max_len);
        return din_w + clog2(max_len);
    endfunction

endpackage

// File: rtl/xfire_acc_dump_sat.sv
// Arithmetic right shift of a block sum followed by signed saturation
// down to the output width; reports whether the value was clipped.
module xfire_acc_dump_sat #(
    parameter int ACC_W  = 20,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 0
) (
    input  logic signed [ACC_W-1:0]  sum,
    output logic signed [DOUT_W-1:0] value,
    output logic                     clipped
);

    // Output range limits expressed at accumulator width so the compare is exact
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = sum >>> SHIFT;

    // Clip to the largest/smallest representable output, otherwise truncate losslessly
    always_comb begin
        value   = shifted[DOUT_W-1:0];
        clipped = 1'b0;
        if (shifted > MAX_V) begin
            value   = {1'b0, {(DOUT_W-1){1'b1}}};
            clipped = 1'b1;
        end else if (shifted < MIN_V) begin
            value   = {1'b1, {(DOUT_W-1){1'b0}}};
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/xfire_acc_dump.sv
// Multi-channel integrate-and-dump accumulator. Sums len+1 accepted
// samples per channel, shifts and saturates the sum, and offers it on a
// one-entry valid/ready register with a sticky overflow flag for drops.
module xfire_acc_dump
    import xfire_acc_dump_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DIN_W   = 12,
    parameter int DOUT_W  = 16,
    parameter int MAX_LEN = 256,
    parameter int SHIFT   = 0,
    localparam int CNT_W  = clog2(MAX_LEN)
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    enable,
    input  logic                    din_valid,
    input  logic [NCH*DIN_W-1:0]    din,
    input  logic [CNT_W-1:0]        len,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [NCH*DOUT_W-1:0]   dout,
    output logic [NCH-1:0]          sat,
    output logic                    ovf
);

    localparam int ACC_W = acc_width(DIN_W, MAX_LEN);

    logic               acc_ok;
    logic               last;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   blk_len;
    dump_action_t       action;

    assign acc_ok = enable & din_valid;

    // On the first sample of a block the live len applies, since len_q only updates at that edge
    assign blk_len = (cnt == '0) ? len : len_q;
    assign last    = acc_ok && (cnt == blk_len);

    // Decide whether a finishing block loads the output register or is lost
    always_comb begin
        action = DUMP_NONE;
        if (last) begin
            if (!dout_valid || dout_ready) begin
                action = DUMP_LOAD;
            end else begin
                action = DUMP_DROP;
            end
        end
    end

    // Sample counter and block-length capture
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt   <= '0;
            len_q <= len;
        end else if (acc_ok) begin
            if (cnt == '0) begin
                len_q <= len;
            end
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output valid and sticky overflow; enable does not gate the output side
    always_ff @(posedge clk) begin
        if (srst) begin
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (action)
                DUMP_LOAD: dout_valid <= 1'b1;
                DUMP_DROP: ovf        <= 1'b1;
                default: begin
                    if (dout_valid && dout_ready) begin
                        dout_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic signed [DIN_W-1:0]  sample;
        logic signed [ACC_W-1:0]  sample_ext;
        logic signed [ACC_W-1:0]  acc;
        logic signed [ACC_W-1:0]  sum;
        logic signed [DOUT_W-1:0] res;
        logic                     res_clip;
        logic signed [DOUT_W-1:0] dout_q;
        logic                     sat_q;

        assign sample     = din[i*DIN_W +: DIN_W];
        assign sample_ext = {{(ACC_W-DIN_W){sample[DIN_W-1]}}, sample};
        assign sum        = acc + sample_ext;

        // Running sum; cleared on the dump so the next block starts from zero with no gap
        always_ff @(posedge clk) begin
            if (srst) begin
                acc <= '0;
            end else if (acc_ok) begin
                if (last) begin
                    acc <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end

        xfire_acc_dump_sat #(
            .ACC_W  (ACC_W),
            .DOUT_W (DOUT_W),
            .SHIFT  (SHIFT)
        ) u_sat (
            .sum     (sum),
            .value   (res),
            .clipped (res_clip)
        );

        // Holding register: only a loading dump changes it, so it stays stable while stalled
        always_ff @(posedge clk) begin
            if (srst) begin
                dout_q <= '0;
                sat_q  <= 1'b0;
            end else if (action == DUMP_LOAD) begin
                dout_q <= res;
                sat_q  <= res_clip;
            end
        end

        assign dout[i*DOUT_W +: DOUT_W] = dout_q;
        assign sat[i]                   = sat_q;
    end

endmodule

// File: tb/tb_xfire_acc_dump.sv
// Self-checking bench for xfire_acc_dump: two instances (SHIFT=0 and SHIFT=2)
// share the same stimulus; a block-level model predicts results and handshakes.
module tb_xfire_acc_dump;

    localparam int NCH     = 2;
    localparam int DIN_W   = 8;
    localparam int DOUT_W  = 8;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 4;

    logic                    clk = 1'b0;
    logic                    srst;
    logic                    enable;
    logic                    din_valid;
    logic [NCH*DIN_W-1:0]    din;
    logic [CNT_W-1:0]        len;
    logic                    dout_ready;

    logic                    dout_valid_a, dout_valid_b;
    logic [NCH*DOUT_W-1:0]   dout_a, dout_b;
    logic [NCH-1:0]          sat_a, sat_b;
    logic                    ovf_a, ovf_b;

    int total = 0;
    int bad   = 0;

    // Model state: samples of the open block and the one-entry output slot
    int m_cnt;
    int m_blen;
    int m_sum   [NCH];
    int m_valid;
    int m_ovf;
    int m_dout  [2][NCH];
    int m_sat   [2][NCH];

    always #5 clk = ~clk;

    xfire_acc_dump #(
        .NCH(NCH), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .MAX_LEN(MAX_LEN), .SHIFT(0)
    ) dut_a (
        .clk(clk), .srst(srst), .enable(enable), .din_valid(din_valid), .din(din),
        .len(len), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
        .dout(dout_a), .sat(sat_a), .ovf(ovf_a)
    );

    xfire_acc_dump #(
        .NCH(NCH), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .MAX_LEN(MAX_LEN), .SHIFT(2)
    ) dut_b (
        .clk(clk), .srst(srst), .enable(enable), .din_valid(din_valid), .din(din),
        .len(len), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
        .dout(dout_b), .sat(sat_b), .ovf(ovf_b)
    );

    function automatic int get_dout(input int k, input int c);
        logic signed [DOUT_W-1:0] v;
        v = (k == 0) ? dout_a[c*DOUT_W +: DOUT_W] : dout_b[c*DOUT_W +: DOUT_W];
        return int'(v);
    endfunction

    function automatic int get_sat(input int k, input int c);
        return (k == 0) ? int'(sat_a[c]) : int'(sat_b[c]);
    endfunction

    // One comparison: counted, asserted, reported on failure
    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance the reference model by one clock using the inputs just applied
    task automatic model_step(input logic en, input logic v, input int d0, input int d1,
                              input int ln, input logic rdy, input logic rst);
        int  xfer;
        int  dumped;
        int  r;
        int  nd [2][NCH];
        int  ns [2][NCH];
        if (rst) begin
            m_cnt = 0; m_valid = 0; m_ovf = 0;
            for (int c = 0; c < NCH; c++) begin
                m_sum[c] = 0;
                for (int k = 0; k < 2; k++) begin m_dout[k][c] = 0; m_sat[k][c] = 0; end
            end
            return;
        end
        xfer   = (m_valid != 0 && rdy) ? 1 : 0;
        dumped = 0;
        if (en && v) begin
            if (m_cnt == 0) m_blen = ln;
            m_sum[0] += d0;
            m_sum[1] += d1;
            m_cnt++;
            if (m_cnt == m_blen + 1) begin
                dumped = 1;
                for (int k = 0; k < 2; k++) begin
                    for (int c = 0; c < NCH; c++) begin
                        r = m_sum[c] >>> ((k == 0) ? 0 : 2);
                        ns[k][c] = 0;
                        if (r > 127) begin r = 127; ns[k][c] = 1; end
                        else if (r < -128) begin r = -128; ns[k][c] = 1; end
                        nd[k][c] = r;
                    end
                end
                for (int c = 0; c < NCH; c++) m_sum[c] = 0;
                m_cnt = 0;
            end
        end
        if (dumped != 0) begin
            if (m_valid == 0 || xfer != 0) begin
                m_valid = 1;
                for (int k = 0; k < 2; k++)
                    for (int c = 0; c < NCH; c++) begin
                        m_dout[k][c] = nd[k][c];
                        m_sat[k][c]  = ns[k][c];
                    end
            end else begin
                m_ovf = 1;
            end
        end else if (xfer != 0) begin
            m_valid = 0;
        end
    endtask

    // Compare both instances against the model after every clock
    task automatic check_output();
        check("valid_s0", int'(dout_valid_a), m_valid);
        check("valid_s2", int'(dout_valid_b), m_valid);
        check("ovf_s0", int'(ovf_a), m_ovf);
        check("ovf_s2", int'(ovf_b), m_ovf);
        if (m_valid != 0) begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("dout_s%0d_ch%0d", k * 2, c), get_dout(k, c), m_dout[k][c]);
                    check($sformatf("sat_s%0d_ch%0d", k * 2, c), get_sat(k, c), m_sat[k][c]);
                end
        end
    endtask

    // Drive one cycle of inputs, clock it, then check the model against both DUTs
    task automatic apply_stimulus(input logic en, input logic v, input int d0, input int d1,
                                  input int ln, input logic rdy, input logic rst);
        logic [DIN_W-1:0] b0;
        logic [DIN_W-1:0] b1;
        b0 = DIN_W'(d0);
        b1 = DIN_W'(d1);
        enable = en; din_valid = v; din = {b1, b0};
        len = CNT_W'(ln); dout_ready = rdy; srst = rst;
        @(posedge clk);
        #1;
        model_step(en, v, d0, d1, ln, rdy, rst);
        check_output();
    endtask

    // Independent literal check of every output being cleared
    task automatic check_cleared(input string tag);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("%s_dout_s%0d_ch%0d", tag, k * 2, c), get_dout(k, c), 0);
                check($sformatf("%s_sat_s%0d_ch%0d", tag, k * 2, c), get_sat(k, c), 0);
            end
        check({tag, "_valid"}, int'(dout_valid_a), 0);
        check({tag, "_ovf"}, int'(ovf_a), 0);
    endtask

    initial begin
        enable = 0; din_valid = 0; din = '0; len = '0; dout_ready = 0; srst = 1;
        m_blen = 0;

        // Reset
        apply_stimulus(0, 0, 0, 0, 3, 1, 1);
        apply_stimulus(0, 0, 0, 0, 3, 1, 1);
        check_cleared("reset");

        // Four samples of 5/-2 with len=3
        for (int n = 0; n < 3; n++) apply_stimulus(1, 1, 5, -2, 3, 1, 0);
        check("t1_no_early_valid", int'(dout_valid_a), 0);
        apply_stimulus(1, 1, 5, -2, 3, 1, 0);
        check("t1_valid", int'(dout_valid_a), 1);
        check("t1_ch0", get_dout(0, 0), 20);
        check("t1_ch1", get_dout(0, 1), -8);
        check("t1_sat", int'(sat_a), 0);
        check("t1_s2_ch0", get_dout(1, 0), 5);
        check("t1_s2_ch1", get_dout(1, 1), -2);
        apply_stimulus(0, 0, 0, 0, 3, 1, 0);

        // Saturation: 4 x 100 / -100
        for (int n = 0; n < 4; n++) apply_stimulus(1, 1, 100, -100, 3, 1, 0);
        check("t2_ch0", get_dout(0, 0), 127);
        check("t2_ch1", get_dout(0, 1), -128);
        check("t2_sat", int'(sat_a), 3);
        check("t2_s2_ch0", get_dout(1, 0), 100);
        check("t2_s2_ch1", get_dout(1, 1), -100);
        check("t2_s2_sat", int'(sat_b), 0);
        apply_stimulus(0, 0, 0, 0, 3, 1, 0);

        // Overflow: len=0, stalled output
        apply_stimulus(1, 1, 7, 0, 0, 0, 0);
        apply_stimulus(1, 1, 8, 0, 0, 0, 0);
        check("t3_ovf", int'(ovf_a), 1);
        check("t3_hold", get_dout(0, 0), 7);
        apply_stimulus(1, 1, 9, 0, 0, 0, 0);
        apply_stimulus(1, 1, 10, 0, 0, 1, 0);
        check("t3_reload", get_dout(0, 0), 10);
        check("t3_reload_valid", int'(dout_valid_a), 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 3, 1, 1);

        // Acceptance gaps via enable=0 and din_valid=0
        for (int n = 0; n < 4; n++) begin
            for (int g = 0; g < (n % 3) + 1; g++)
                apply_stimulus((g % 2) == 1, (g % 2) == 0, 50, 50, 3, 1, 0);
            apply_stimulus(1, 1, 5, -2, 3, 1, 0);
        end
        check("t4_ch0", get_dout(0, 0), 20);
        check("t4_ch1", get_dout(0, 1), -8);
        apply_stimulus(0, 0, 0, 0, 3, 1, 0);

        // Length change mid-block applies to the next block
        apply_stimulus(1, 1, 1, 2, 3, 1, 0);
        apply_stimulus(1, 1, 1, 2, 3, 1, 0);
        apply_stimulus(1, 1, 1, 2, 1, 1, 0);
        apply_stimulus(1, 1, 1, 2, 1, 1, 0);
        check("t5_blk1_ch0", get_dout(0, 0), 4);
        check("t5_blk1_ch1", get_dout(0, 1), 8);
        apply_stimulus(1, 1, 1, 2, 1, 1, 0);
        apply_stimulus(1, 1, 1, 2, 1, 1, 0);
        check("t5_blk2_ch0", get_dout(0, 0), 2);
        check("t5_blk2_valid", int'(dout_valid_a), 1);
        for (int n = 0; n < 16; n++) apply_stimulus(1, 1, 127, -128, 15, 1, 0);
        check("t5_max_ch0", get_dout(0, 0), 127);
        check("t5_max_sat", int'(sat_a), 3);
        check("t5_max_s2_ch0", get_dout(1, 0), 127);
        apply_stimulus(0, 0, 0, 0, 3, 1, 0);

        // Reset mid-block, then a clean block, then reset while holding a result
        apply_stimulus(1, 1, 9, 9, 3, 1, 0);
        apply_stimulus(1, 1, 9, 9, 3, 1, 0);
        apply_stimulus(0, 0, 0, 0, 3, 1, 1);
        check_cleared("t6_mid");
        for (int n = 0; n < 4; n++) apply_stimulus(1, 1, 2, 3, 3, 0, 0);
        check("t6_ch0", get_dout(0, 0), 8);
        check("t6_ch1", get_dout(0, 1), 12);
        apply_stimulus(1, 1, 1, 1, 0, 0, 0);
        check("t6_ovf", int'(ovf_a), 1);
        apply_stimulus(0, 0, 0, 0, 3, 0, 1);
        check_cleared("t6_held");

        // Randomized traffic against the model
        begin
            int ln;
            ln = 2;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(7) == 0) ln = $urandom_range(5);
                if ($urandom_range(60) == 0) ln = $urandom_range(15);
                apply_stimulus($urandom_range(3) != 0, $urandom_range(3) != 0,
                               int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                               ln, $urandom_range(2) != 0, $urandom_range(149) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
